// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the ALU control sequencer: opcodes, ALU codes, IR fields, state enum.
// ALU_SEQ_MULDIV_EN makes mul/div decode as legal; otherwise they classify as undefined.
package cpu_pkg;

    localparam int MULDIV_STATES = 1;

    localparam logic [4:0] OPC_ADD  = 5'b00011;
    localparam logic [4:0] OPC_SUB  = 5'b00100;
    localparam logic [4:0] OPC_SHR  = 5'b00101;
    localparam logic [4:0] OPC_SHL  = 5'b00110;
    localparam logic [4:0] OPC_ROR  = 5'b00111;
    localparam logic [4:0] OPC_ROL  = 5'b01000;
    localparam logic [4:0] OPC_AND  = 5'b01001;
    localparam logic [4:0] OPC_OR   = 5'b01010;
    localparam logic [4:0] OPC_MUL  = 5'b01110;
    localparam logic [4:0] OPC_DIV  = 5'b01111;
    localparam logic [4:0] OPC_NEG  = 5'b10000;
    localparam logic [4:0] OPC_NOT  = 5'b10001;
    localparam logic [4:0] OPC_NOP  = 5'b11010;
    localparam logic [4:0] OPC_HALT = 5'b11011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_SHR = 4'b0100;
    localparam logic [3:0] ALU_SHL = 4'b0101;
    localparam logic [3:0] ALU_ROR = 4'b0110;
    localparam logic [3:0] ALU_ROL = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;
    localparam logic [3:0] ALU_DIV = 4'b1001;
    localparam logic [3:0] ALU_NEG = 4'b1010;
    localparam logic [3:0] ALU_NOT = 4'b1011;

    localparam int IR_OPC_MSB = 31;
    localparam int IR_OPC_LSB = 27;
    localparam int IR_RA_MSB  = 26;
    localparam int IR_RA_LSB  = 23;
    localparam int IR_RB_MSB  = 22;
    localparam int IR_RB_LSB  = 19;
    localparam int IR_RC_MSB  = 18;
    localparam int IR_RC_LSB  = 15;

    typedef enum logic [3:0] {
        ST_IDLE, ST_F0, ST_F1, ST_F2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALTED
    } state_e;

    typedef enum logic [2:0] {
        CLS_BINARY, CLS_UNARY, CLS_MULDIV, CLS_NOP, CLS_HALT, CLS_UNDEF
    } op_class_e;

    function automatic op_class_e op_class(input logic [4:0] opc);
        op_class_e cls;
        cls = CLS_UNDEF;
        case (opc)
            OPC_ADD, OPC_SUB, OPC_SHR, OPC_SHL,
            OPC_ROR, OPC_ROL, OPC_AND, OPC_OR:  cls = CLS_BINARY;
            OPC_NEG, OPC_NOT:                   cls = CLS_UNARY;
`ifdef ALU_SEQ_MULDIV_EN
            OPC_MUL, OPC_DIV:                   cls = CLS_MULDIV;
`endif
            OPC_NOP:                            cls = CLS_NOP;
            OPC_HALT:                           cls = CLS_HALT;
            default:                            cls = CLS_UNDEF;
        endcase
        return cls;
    endfunction

    function automatic logic [3:0] alu_code(input logic [4:0] opc);
        logic [3:0] code;
        code = ALU_AND;
        case (opc)
            OPC_OR:  code = ALU_OR;
            OPC_ADD: code = ALU_ADD;
            OPC_SUB: code = ALU_SUB;
            OPC_SHR: code = ALU_SHR;
            OPC_SHL: code = ALU_SHL;
            OPC_ROR: code = ALU_ROR;
            OPC_ROL: code = ALU_ROL;
            OPC_MUL: code = ALU_MUL;
            OPC_DIV: code = ALU_DIV;
            OPC_NEG: code = ALU_NEG;
            OPC_NOT: code = ALU_NOT;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Control bundle between the sequencer (master) and the datapath side (slave).
interface alu_seq_ctrl_if;
    logic        start;
    logic        mem_rdy;
    logic [31:0] ir;
    logic [15:0] gpr_in;
    logic [15:0] gpr_out;
    logic        pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, read, ir_in;
    logic        y_in, z_in, z_low_out, z_high_out, hi_in, lo_in, hi_out, lo_out;
    logic [3:0]  alu_op;
    logic        busy, halted, illegal;

    modport master (
        input  start, mem_rdy, ir,
        output gpr_in, gpr_out, pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, read, ir_in,
               y_in, z_in, z_low_out, z_high_out, hi_in, lo_in, hi_out, lo_out,
               alu_op, busy, halted, illegal
    );

    modport slave (
        output start, mem_rdy, ir,
        input  gpr_in, gpr_out, pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, read, ir_in,
               y_in, z_in, z_low_out, z_high_out, hi_in, lo_in, hi_out, lo_out,
               alu_op, busy, halted, illegal
    );
endinterface

// File: rtl/alu_seq_ctrl_reg_sel_decode.sv
// 4-bit register field to 16-bit one-hot enable; all zero when not enabled.
module reg_sel_decode (
    input  logic [3:0]  sel_i,
    input  logic        en_i,
    output logic [15:0] onehot_o
);
    assign onehot_o = en_i ? (16'd1 << sel_i) : 16'd0;
endmodule

// File: rtl/alu_seq_ctrl.sv
// Fetch/execute control sequencer, Moore outputs decoded from state and IR, one state per clock.
// ALU_SEQ_MULDIV_EN enables the two-state mul/div writeback (LO then HI); undefined -> illegal.
module alu_seq_ctrl
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    alu_seq_ctrl_if.master bus
);
    state_e    state_q, state_d;
    logic      illegal_q, illegal_d;
    logic      gin_en, gout_en, gout_rc;
    logic [3:0] ra, rb, rc;
    logic [4:0] opc;
    op_class_e cls;
    logic      ir_unused;

    assign opc       = bus.ir[IR_OPC_MSB:IR_OPC_LSB];
    assign ra        = bus.ir[IR_RA_MSB:IR_RA_LSB];
    assign rb        = bus.ir[IR_RB_MSB:IR_RB_LSB];
    assign rc        = bus.ir[IR_RC_MSB:IR_RC_LSB];
    assign cls       = op_class(opc);
    assign ir_unused = ^bus.ir[IR_RC_LSB-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        illegal_d      = illegal_q;
        gin_en         = 1'b0;
        gout_en        = 1'b0;
        gout_rc        = 1'b0;
        bus.pc_out     = 1'b0;
        bus.pc_in      = 1'b0;
        bus.inc_pc     = 1'b0;
        bus.mar_in     = 1'b0;
        bus.mdr_in     = 1'b0;
        bus.mdr_out    = 1'b0;
        bus.read       = 1'b0;
        bus.ir_in      = 1'b0;
        bus.y_in       = 1'b0;
        bus.z_in       = 1'b0;
        bus.z_low_out  = 1'b0;
        bus.z_high_out = 1'b0;
        bus.hi_in      = 1'b0;
        bus.lo_in      = 1'b0;
        bus.hi_out     = 1'b0;
        bus.lo_out     = 1'b0;
        bus.alu_op     = ALU_AND;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_F0;
            ST_F0: begin
                bus.pc_out = 1'b1;
                bus.mar_in = 1'b1;
                bus.inc_pc = 1'b1;
                state_d    = ST_F1;
            end
            ST_F1: begin
                bus.read   = 1'b1;
                bus.mdr_in = 1'b1;
                if (bus.mem_rdy) state_d = ST_F2;
            end
            ST_F2: begin
                bus.mdr_out = 1'b1;
                bus.ir_in   = 1'b1;
                state_d     = ST_T3;
            end
            ST_T3: begin
                case (cls)
                    CLS_BINARY, CLS_MULDIV: begin
                        gout_en  = 1'b1;
                        bus.y_in = 1'b1;
                        state_d  = ST_T4;
                    end
                    CLS_UNARY: begin
                        gout_en    = 1'b1;
                        bus.z_in   = 1'b1;
                        bus.alu_op = alu_code(opc);
                        state_d    = ST_T4;
                    end
                    CLS_NOP:  state_d = ST_F0;
                    CLS_HALT: state_d = ST_HALTED;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = ST_HALTED;
                    end
                endcase
            end
            ST_T4: begin
                if (cls == CLS_UNARY) begin
                    bus.z_low_out = 1'b1;
                    gin_en        = 1'b1;
                    state_d       = ST_F0;
                end else begin
                    gout_en    = 1'b1;
                    gout_rc    = 1'b1;
                    bus.z_in   = 1'b1;
                    bus.alu_op = alu_code(opc);
                    state_d    = ST_T5;
                end
            end
            ST_T5: begin
                bus.z_low_out = 1'b1;
`ifdef ALU_SEQ_MULDIV_EN
                if (cls == CLS_MULDIV) begin
                    bus.lo_in = 1'b1;
                    state_d   = ST_T6;
                end else begin
                    gin_en  = 1'b1;
                    state_d = ST_F0;
                end
`else
                gin_en  = 1'b1;
                state_d = ST_F0;
`endif
            end
`ifdef ALU_SEQ_MULDIV_EN
            ST_T6: begin
                bus.z_high_out = 1'b1;
                bus.hi_in      = 1'b1;
                state_d        = ST_F0;
            end
`endif
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign bus.busy    = (state_q != ST_IDLE) && (state_q != ST_HALTED);
    assign bus.halted  = (state_q == ST_HALTED);
    assign bus.illegal = illegal_q;

    reg_sel_decode u_gpr_in_dec (
        .sel_i    (ra),
        .en_i     (gin_en),
        .onehot_o (bus.gpr_in)
    );

    reg_sel_decode u_gpr_out_dec (
        .sel_i    (gout_rc ? rc : rb),
        .en_i     (gout_en),
        .onehot_o (bus.gpr_out)
    );
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench: per-cycle expected control vectors from an instruction-level model, checked at negedge.
module tb_alu_seq_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_seq_ctrl_if bus_if ();
    alu_seq_ctrl dut (.clk(clk), .reset(reset), .bus(bus_if));

    typedef struct packed {
        logic [15:0] gin;
        logic [15:0] gout;
        logic pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, read, ir_in;
        logic y_in, z_in, z_low_out, z_high_out, hi_in, lo_in, hi_out, lo_out;
        logic [3:0] alu_op;
        logic busy, halted, illegal;
    } vec_t;

    localparam int K_BIN = 0, K_UN = 1, K_MD = 2, K_NOP = 3, K_HALT = 4, K_ILL = 5;

    vec_t  exp_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    logic  m_illegal;

    logic [4:0] run_ops [0:11] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                                   5'b01001, 5'b01010, 5'b10000, 5'b10001, 5'b11010, 5'b01110};
    logic [4:0] bad_ops [0:3]  = '{5'b00000, 5'b01011, 5'b10101, 5'b11111};

    function automatic vec_t actual();
        vec_t a;
        a.gin = bus_if.gpr_in;      a.gout = bus_if.gpr_out;
        a.pc_out = bus_if.pc_out;   a.pc_in = bus_if.pc_in;     a.inc_pc = bus_if.inc_pc;
        a.mar_in = bus_if.mar_in;   a.mdr_in = bus_if.mdr_in;   a.mdr_out = bus_if.mdr_out;
        a.read = bus_if.read;       a.ir_in = bus_if.ir_in;     a.y_in = bus_if.y_in;
        a.z_in = bus_if.z_in;       a.z_low_out = bus_if.z_low_out;
        a.z_high_out = bus_if.z_high_out;
        a.hi_in = bus_if.hi_in;     a.lo_in = bus_if.lo_in;
        a.hi_out = bus_if.hi_out;   a.lo_out = bus_if.lo_out;
        a.alu_op = bus_if.alu_op;   a.busy = bus_if.busy;
        a.halted = bus_if.halted;   a.illegal = bus_if.illegal;
        return a;
    endfunction

    always @(negedge clk) begin
        vec_t  e, a;
        string t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = actual();
            n_checks++;
            if (a === e) n_pass++;
            else $display("FAIL %s: got %h, expected %h", t, a, e);
        end
    end

    function automatic logic rbit();
        return ($urandom_range(0, 1) != 0);
    endfunction

    function automatic int kind_of(input logic [4:0] op);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110,
            5'b00111, 5'b01000, 5'b01001, 5'b01010: return K_BIN;
            5'b10000, 5'b10001:                     return K_UN;
`ifdef ALU_SEQ_MULDIV_EN
            5'b01110, 5'b01111:                     return K_MD;
`endif
            5'b11010:                               return K_NOP;
            5'b11011:                               return K_HALT;
            default:                                return K_ILL;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [4:0] op);
        case (op)
            5'b01010: return 4'b0001;  5'b00011: return 4'b0010;
            5'b00100: return 4'b0011;  5'b00101: return 4'b0100;
            5'b00110: return 4'b0101;  5'b00111: return 4'b0110;
            5'b01000: return 4'b0111;  5'b01110: return 4'b1000;
            5'b01111: return 4'b1001;  5'b10000: return 4'b1010;
            5'b10001: return 4'b1011;  default:  return 4'b0000;
        endcase
    endfunction

    function automatic vec_t base();
        vec_t v = '0;
        v.busy    = 1'b1;
        v.illegal = m_illegal;
        return v;
    endfunction

    // One clock of stimulus: drive inputs for this cycle and queue what the outputs must be.
    task automatic cyc(input vec_t e, input string t, input logic st, input logic mr);
        bus_if.start   = st;
        bus_if.mem_rdy = mr;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset     = 1'b1;
        m_illegal = 1'b0;
        repeat (n) cyc('0, "reset", rbit(), rbit());
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc('0, "idle", 1'b0, rbit());
        cyc('0, "idle start", 1'b1, rbit());
    endtask

    task automatic halted_cycles(input int n);
        vec_t v;
        repeat (n) begin
            v = '0;
            v.halted  = 1'b1;
            v.illegal = m_illegal;
            cyc(v, "halted", rbit(), rbit());
        end
    endtask

    // outcome: 0 = next fetch follows, 1 = halted, 2 = aborted by reset
    task automatic run_instr(input logic [31:0] ins, input int waits, input int abort_at,
                             output int outcome);
        vec_t  seq[$];
        string tg[$];
        logic  mr[$];
        vec_t  v;
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        int k, t3;
        op = ins[31:27]; ra = ins[26:23]; rb = ins[22:19]; rc = ins[18:15];
        k  = kind_of(op);

        v = base(); v.pc_out = 1'b1; v.mar_in = 1'b1; v.inc_pc = 1'b1;
        seq.push_back(v); tg.push_back("F0"); mr.push_back(rbit());
        for (int i = 0; i <= waits; i++) begin
            v = base(); v.read = 1'b1; v.mdr_in = 1'b1;
            seq.push_back(v); tg.push_back("F1"); mr.push_back(i == waits);
        end
        v = base(); v.mdr_out = 1'b1; v.ir_in = 1'b1;
        seq.push_back(v); tg.push_back("F2"); mr.push_back(rbit());
        t3 = seq.size();

        if (k == K_BIN || k == K_MD) begin
            v = base(); v.gout = 16'd1 << rb; v.y_in = 1'b1;
            seq.push_back(v); tg.push_back("T3");
            v = base(); v.gout = 16'd1 << rc; v.z_in = 1'b1; v.alu_op = alu_of(op);
            seq.push_back(v); tg.push_back("T4");
            if (k == K_BIN) begin
                v = base(); v.z_low_out = 1'b1; v.gin = 16'd1 << ra;
                seq.push_back(v); tg.push_back("T5");
            end else begin
                v = base(); v.z_low_out = 1'b1; v.lo_in = 1'b1;
                seq.push_back(v); tg.push_back("T5");
                v = base(); v.z_high_out = 1'b1; v.hi_in = 1'b1;
                seq.push_back(v); tg.push_back("T6");
            end
        end else if (k == K_UN) begin
            v = base(); v.gout = 16'd1 << rb; v.z_in = 1'b1; v.alu_op = alu_of(op);
            seq.push_back(v); tg.push_back("T3");
            v = base(); v.z_low_out = 1'b1; v.gin = 16'd1 << ra;
            seq.push_back(v); tg.push_back("T4");
        end else begin
            seq.push_back(base()); tg.push_back("T3");
        end
        while (mr.size() < seq.size()) mr.push_back(rbit());

        outcome = 0;
        for (int i = 0; i < seq.size(); i++) begin
            if (i == t3) bus_if.ir = ins;
            if (i == abort_at) begin
                reset     = 1'b1;
                m_illegal = 1'b0;
                cyc('0, $sformatf("reset in %s", tg[i]), rbit(), rbit());
                cyc('0, "reset hold", rbit(), rbit());
                reset   = 1'b0;
                outcome = 2;
                return;
            end
            cyc(seq[i], $sformatf("%s ir=%h", tg[i], ins), rbit(), mr[i]);
        end
        if (k == K_HALT) outcome = 1;
        if (k == K_ILL) begin
            m_illegal = 1'b1;
            outcome   = 1;
        end
    endtask

    function automatic logic [31:0] mk_ins(input logic [4:0] op);
        return {op, 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom)};
    endfunction

    initial begin
        int oc, waits, abort_at, sel;
        logic [31:0] ins;
        reset          = 1'b1;
        bus_if.start   = 1'b0;
        bus_if.mem_rdy = 1'b0;
        bus_if.ir      = '0;
        m_illegal      = 1'b0;
        @(posedge clk);
        #1;

        do_reset(2);
        idle(2);
        run_instr(32'h4A920000, 0, -1, oc);
        run_instr(32'h4A920000, 3, -1, oc);
        run_instr(32'h80900000, 0, -1, oc);
        run_instr(32'h71100000, 1, -1, oc);
        if (oc == 0) run_instr(32'hD8000000, 0, -1, oc);
        halted_cycles(4);

        do_reset(1);
        idle(1);
        run_instr(32'hF8000000, 0, -1, oc);
        halted_cycles(3);
        do_reset(2);
        idle(3);
        run_instr(32'h1A920000, 1, 5, oc);
        idle(3);
        run_instr(32'h0A920000, 0, -1, oc);

        for (int r = 0; r < 25; r++) begin
            do_reset(1 + $urandom_range(0, 1));
            idle($urandom_range(0, 3));
            oc = 0;
            for (int j = 0; j < 12 && oc == 0; j++) begin
                waits    = $urandom_range(0, 3);
                abort_at = -1;
                if (j == 11) begin
                    sel = $urandom_range(0, 2);
                    if (sel == 0)      ins = mk_ins(5'b11011);
                    else if (sel == 1) ins = mk_ins(bad_ops[$urandom_range(0, 3)]);
                    else begin
                        ins      = mk_ins(run_ops[$urandom_range(0, 11)]);
                        abort_at = $urandom_range(0, waits + 4);
                    end
                end else begin
                    ins = mk_ins(run_ops[$urandom_range(0, 11)]);
                    if (ins[31:27] == 5'b01110 && rbit()) ins[27] = 1'b1;
                end
                run_instr(ins, waits, abort_at, oc);
            end
            if (oc == 1) halted_cycles($urandom_range(1, 4));
        end

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard drain: got %0d entries left, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Control sequencer for the single-bus datapath. It generates every register-enable, bus-drive, memory-read and ALU-op strobe that the datapath needs to fetch an instruction and execute the register-to-register ALU subset. In the processor it replaces hand-driven control stimulus: it sits beside `datapath`, receives the IR contents and memory-ready back, and drives the datapath's control ports one state per clock.

## Interface
- `MULDIV_STATES`, default 1: number of extra writeback states for mul/div; fixed at 1 (HI after LO).
- `clk  in  1` — system clock; all state changes on rising edge.
- `reset  in  1` — asynchronous, active-high reset.
- `start  in  1` — begin fetching from the current PC. Sampled only in IDLE.
- `mem_rdy  in  1` — memory read data valid this cycle.
- `ir  in  32` — datapath IR. Fields: opcode[31:27], ra[26:23], rb[22:19], rc[18:15].
- `gpr_in / gpr_out  out  16` — one-hot register load / drive enables.
- `pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, read, ir_in, y_in, z_in, z_low_out, z_high_out, hi_in, lo_in, hi_out, lo_out  out  1 each` — datapath strobes.
- `alu_op  out  4` — ALU function select.
- `busy  out  1` — high in every state except IDLE and HALTED.
- `halted  out  1` — high in HALTED.
- `illegal  out  1` — sticky; set when an undefined opcode is decoded.

## Operation
- States: IDLE, F0, F1, F2, T3, T4, T5, T6, HALTED.
- IDLE: no strobes. Moves to F0 on `start`.
- F0: `pc_out`, `mar_in`, `inc_pc`. Moves to F1.
- F1: `read`, `mdr_in`. Holds while `mem_rdy`=0; moves to F2 on the cycle `mem_rdy`=1.
- F2: `mdr_out`, `ir_in`. Moves to T3.
- Decode happens in T3 from the registered `ir`.
- Binary ALU ops (and, or, add, sub, shr, shl, ror, rol):
  - T3: `gpr_out[rb]`, `y_in`.
  - T4: `gpr_out[rc]`, `z_in`, `alu_op` = op.
  - T5: `z_low_out`, `gpr_in[ra]`.
  - Then F0.
- Unary ops (neg, not):
  - T3: `gpr_out[rb]`, `z_in`, `alu_op` = op.
  - T4: `z_low_out`, `gpr_in[ra]`.
  - Then F0.
- mul/div:
  - T3 and T4 as for binary ops.
  - T5: `z_low_out`, `lo_in`.
  - T6: `z_high_out`, `hi_in`.
  - Then F0.
- nop: T3 asserts nothing, then F0.
- halt: T3 asserts nothing, then HALTED.
- Undefined opcode: T3 asserts nothing, sets `illegal`, then HALTED.
- HALTED is left only by `reset`.
- `alu_op` is 4'b0000 (AND) in every state where it is not specified. `z_in` is never asserted in those states.
- Opcodes: add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010, mul 01110, div 01111, neg 10000, not 10001, nop 11010, halt 11011.
- alu_op codes: and 0000, or 0001, add 0010, sub 0011, shr 0100, shl 0101, ror 0110, rol 0111, mul 1000, div 1001, neg 1010, not 1011.
- `gpr_in` and `gpr_out` are never both nonzero in the same cycle.
- At most one bus driver (`*_out`) is active per cycle.

## Timing
- Outputs are Moore: decoded combinationally from the state register and `ir`. No output depends on `start` or `mem_rdy` directly.
- Reset is asynchronous. While `reset` is high:
  - state = IDLE;
  - every output = 0;
  - `illegal` is cleared.
- Reset asserted mid-instruction aborts immediately. No write strobe may appear on the cycle reset deasserts.
- Latency from F0 entry to the writeback cycle, with `mem_rdy` tied high:
  - binary ops: 6 cycles;
  - unary ops: 5 cycles;
  - mul/div: 7 cycles (writebacks in cycles 6 and 7).
- Each cycle `mem_rdy` stays low in F1 adds one cycle to these latencies.
- The next F0 immediately follows the last execute state; there are no bubbles.
- `start` asserted outside IDLE is ignored. `start` held high in IDLE behaves as a single pulse.
- `mem_rdy` outside F1 is ignored.

## Configuration
- `ALU_SEQ_MULDIV_EN`:
  - Defined: mul/div sequence through T5/T6 as described.
  - Undefined: opcodes 01110/01111 are treated as undefined (set `illegal`, go to HALTED). T6 is removed, and `hi_in`, `lo_in`, `z_high_out` are tied 0.
- `hi_out` and `lo_out` are tied 0 in both builds.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode localparams;
  - alu_op localparams;
  - the state enum;
  - IR field bit positions.
- One sub-module, `reg_sel_decode`: 4-bit field plus enable in, 16-bit one-hot out. Instantiated twice, once for `gpr_in` and once for `gpr_out`.

## Test plan
- **Reset and start:** reset, start, `mem_rdy`=1, F2 loads `ir`=0x4A920000 (and R5,R2,R4).
  - T3: `gpr_out`=0x0004, `y_in`=1.
  - T4: `gpr_out`=0x0010, `z_in`=1, `alu_op`=0000.
  - T5: `gpr_in`=0x0020, `z_low_out`=1.
  - Next cycle is F0.
- **Memory wait:** `mem_rdy` held low for 3 cycles in F1 → `read` and `mdr_in` stay high for 4 cycles total; `ir_in` pulses once, afterwards.
- **mul/div:** `ir`=0x71100000 (mul, rb=R2, rc=R0) with macro defined → `lo_in` in T5, `hi_in` in T6. With macro undefined → HALTED, `illegal`=1, `busy`=0.
- **Unary op:** `ir`=0x80900000 (neg R1,R2) → T3: `gpr_out`=0x0004, `z_in`=1, `alu_op`=1010. T4: `gpr_in`=0x0002.
- **Halt and undefined opcode:** halt 0xD8000000 → HALTED, `illegal`=0, `start` ignored. Opcode 11111 → `illegal`=1. Reset clears both.
- **Reset mid-instruction:** assert `reset` in T4 → all outputs 0 in that same cycle. After release, state stays IDLE until `start`.
